game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter LIVES, default 3, meaning lives loaded at reset and at restart (1..3).
REQ-002 SHALL have parameter HIT_FRAMES, default 64, meaning frame_tick count spent in HIT (2..127).
REQ-003 SHALL have port clk  input  1  system clock; the block has one clock only.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port move_btn  input  1  raw asynchronous player button.
REQ-006 SHALL have port collision  input  1  chicken/obstacle pixel overlap, a level that may pulse many cycles per frame.
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse once per video frame.
REQ-008 SHALL have port play_rst  output  1  reset to the scroll and score datapath.
REQ-009 SHALL have port scroll_en  output  1  scroll/score datapath may advance.
REQ-010 SHALL have port lives  output  2  remaining lives.
REQ-011 SHALL have port state  output  3  current state code.
REQ-012 SHALL have port flash  output  1  chicken blink during HIT.
REQ-013 SHALL have port game_over  output  1  high in OVER.

Function
REQ-014 SHALL implement FSM states IDLE=0, PLAY=1, HIT=2, RESPAWN=3, OVER=4; codes 5-7 SHALL go to IDLE on the next clk.
REQ-015 SHALL pass move_btn through a 2-flop synchronizer plus a previous-value flop; btn_rise = sync2 & ~prev.
REQ-016 SHALL reach state==PLAY at the 3rd rising clk edge after move_btn is first sampled high, in IDLE (btn_rise -> PLAY).
REQ-017 SHALL ignore btn_rise in PLAY, HIT and RESPAWN.
REQ-018 SHALL ignore collision outside PLAY.
REQ-019 SHALL, in PLAY, set sticky hit_pending on any cycle with collision=1.
REQ-020 SHALL move PLAY -> HIT on the frame_tick cycle when hit_pending or collision is 1.
REQ-021 SHALL, on HIT entry, clear hit_pending, clear the 7-bit frame_cnt, and decrement lives, saturating at 0.
REQ-022 SHALL, in HIT, increment frame_cnt on each frame_tick.
REQ-023 SHALL leave HIT on the frame_tick where frame_cnt==HIT_FRAMES-1: to OVER if lives==0, else to RESPAWN.
REQ-024 SHALL hold RESPAWN exactly one cycle, then go to PLAY.
REQ-025 SHALL, in OVER, on btn_rise reload lives=LIVES and go to RESPAWN.
REQ-026 SHALL decode outputs from registered state (Moore, no combinational path from inputs).
REQ-027 SHALL drive play_rst=1 in IDLE and RESPAWN, else 0.
REQ-028 SHALL drive scroll_en=1 only in PLAY.
REQ-029 SHALL drive flash=frame_cnt[3] in HIT, else 0.
REQ-030 SHALL drive game_over=1 only in OVER.
REQ-031 SHALL hold frame_cnt and lives when not in the transitions above.

Reset
REQ-032 SHALL make reset dominate all other inputs, including mid-HIT and mid-RESPAWN.
REQ-033 SHALL, on reset, set state=IDLE, lives=LIVES, frame_cnt=0, hit_pending=0, and synchronizer flops=0.
REQ-034 SHALL, from the cycle after reset, drive play_rst=1, scroll_en=0, flash=0, game_over=0, lives=LIVES.

Verification
REQ-035 SHALL verify: reset, move_btn high from cycle 10 -> state=1 and scroll_en=1 at edge 12; play_rst=0 from then.
REQ-036 SHALL verify: PLAY, collision 1-cycle pulse, frame_tick 5 cycles later -> state=2 next cycle, lives 3->2, scroll_en=0.
REQ-037 SHALL verify: HIT with 64 frame_ticks -> flash toggles every 8 ticks; after the 64th tick state=3 for one cycle with play_rst=1, then state=1.
REQ-038 SHALL verify: three hits -> after the third HIT, lives=0, state=4, game_over=1; btn_rise -> state=3, lives=3, then state=1.
REQ-039 SHALL verify: collision held in IDLE/HIT and button pressed during HIT -> no state or lives change.
REQ-040 SHALL verify: reset at HIT frame_cnt=20 -> next cycle state=0, lives=3, flash=0, play_rst=1.

Source files
------------

// File: rtl/game_ctrl.sv
// Game-flow controller: button synchronizer, life counting and hit/respawn timing
// for the scrolling chicken game. All outputs decode from registered state only.
module game_ctrl #(
    parameter int LIVES      = 3,
    parameter int HIT_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_btn,
    input  logic       collision,
    input  logic       frame_tick,
    output logic       play_rst,
    output logic       scroll_en,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       flash,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_HIT     = 3'd2,
        S_RESPAWN = 3'd3,
        S_OVER    = 3'd4
    } state_e;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [6:0] LAST_FRAME = 7'(HIT_FRAMES - 1);

    state_e     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [6:0] frame_cnt_q, frame_cnt_d;
    logic       hit_pending_q, hit_pending_d;
    logic       sync1_q, sync2_q, prev_q;
    logic       btn_rise;

    assign btn_rise = sync2_q & ~prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            lives_q       <= LIVES_INIT;
            frame_cnt_q   <= 7'd0;
            hit_pending_q <= 1'b0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            frame_cnt_q   <= frame_cnt_d;
            hit_pending_q <= hit_pending_d;
            sync1_q       <= move_btn;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        frame_cnt_d   = frame_cnt_q;
        hit_pending_d = hit_pending_q;
        case (state_q)
            S_IDLE: begin
                if (btn_rise) state_d = S_PLAY;
            end
            S_PLAY: begin
                // A collision can land between frame ticks; remember it until the next tick.
                if (collision) hit_pending_d = 1'b1;
                if (frame_tick && (hit_pending_q || collision)) begin
                    state_d       = S_HIT;
                    hit_pending_d = 1'b0;
                    frame_cnt_d   = 7'd0;
                    lives_d       = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                end
            end
            S_HIT: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_cnt_q + 7'd1;
                    if (frame_cnt_q == LAST_FRAME)
                        state_d = (lives_q == 2'd0) ? S_OVER : S_RESPAWN;
                end
            end
            S_RESPAWN: begin
                state_d = S_PLAY;
            end
            S_OVER: begin
                if (btn_rise) begin
                    lives_d = LIVES_INIT;
                    state_d = S_RESPAWN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state     = state_q;
    assign lives     = lives_q;
    assign play_rst  = (state_q == S_IDLE) || (state_q == S_RESPAWN);
    assign scroll_en = (state_q == S_PLAY);
    assign flash     = (state_q == S_HIT) ? frame_cnt_q[3] : 1'b0;
    assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: expected output vectors are queued by the
// stimulus and compared by an independent negedge monitor.
module tb_game_ctrl;

  localparam int W = 9;  // {state, lives, play_rst, scroll_en, flash, game_over}

  logic       clk = 1'b0;
  logic       reset, move_btn, collision, frame_tick;
  logic       play_rst, scroll_en, flash, game_over;
  logic [1:0] lives;
  logic [2:0] state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           pass_cnt = 0;
  int           chk_cnt  = 0;

  game_ctrl #(.LIVES(3), .HIT_FRAMES(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .move_btn  (move_btn),
    .collision (collision),
    .frame_tick(frame_tick),
    .play_rst  (play_rst),
    .scroll_en (scroll_en),
    .lives     (lives),
    .state     (state),
    .flash     (flash),
    .game_over (game_over)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // monitor: compares every vector queued since the last falling edge
  always @(negedge clk) begin
    logic [W-1:0] act, exp_v;
    string nm;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act   = {state, lives, play_rst, scroll_en, flash, game_over};
      chk_cnt++;
      if (act === exp_v) pass_cnt++;
      else $display("FAIL %s: got %b expected %b (state,lives,play_rst,scroll_en,flash,game_over)",
                    nm, act, exp_v);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W-1:0] exp_vec(input logic [2:0] st, input logic [1:0] lv, input logic fl);
    logic pr, se, go;
    pr = (st == 3'd0) || (st == 3'd3);
    se = (st == 3'd1);
    go = (st == 3'd4);
    return {st, lv, pr, se, fl, go};
  endfunction

  task automatic expect_st(input string nm, input logic [2:0] st, input logic [1:0] lv, input logic fl);
    exp_q.push_back(exp_vec(st, lv, fl));
    name_q.push_back(nm);
  endtask

  task automatic check_now(input string nm, input logic [2:0] st, input logic [1:0] lv, input logic fl);
    logic [W-1:0] act, exp_v;
    exp_v = exp_vec(st, lv, fl);
    act   = {state, lives, play_rst, scroll_en, flash, game_over};
    chk_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got %b expected %b (state,lives,play_rst,scroll_en,flash,game_over)",
                  nm, act, exp_v);
  endtask

  task automatic wait_state(input string nm, input logic [2:0] st, input logic [1:0] lv, input int max_cyc);
    int n;
    n = 0;
    while ((state !== st) && (n < max_cyc)) begin
      step(1);
      n++;
    end
    if (state !== st) begin
      chk_cnt++;
      $display("FAIL %s: wait expired after %0d cycles, state=%0d expected %0d", nm, max_cyc, state, st);
    end else begin
      check_now(nm, st, lv, 1'b0);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(1);
  endtask

  task automatic hit_now();
    collision  = 1'b1;
    frame_tick = 1'b1;
    step(1);
    collision  = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic last_tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic button_rise();
    move_btn = 1'b0;
    step(3);
    move_btn = 1'b1;
    step(3);
  endtask

  initial begin
    reset = 1'b1; move_btn = 1'b0; collision = 1'b0; frame_tick = 1'b0;
    step(2);
    check_now("reset_state_direct", 3'd0, 2'd3, 1'b0);
    expect_st("reset_state", 3'd0, 2'd3, 1'b0);
    reset = 1'b0;
    step(1);
    collision  = 1'b1;
    frame_tick = 1'b1;
    step(3);
    expect_st("idle_ignores_collision", 3'd0, 2'd3, 1'b0);
    collision  = 1'b0;
    frame_tick = 1'b0;
    step(3);

    // button: sampled at edge 1, PLAY at edge 3
    move_btn = 1'b1;
    step(1);
    expect_st("btn_edge1_idle", 3'd0, 2'd3, 1'b0);
    step(1);
    expect_st("btn_edge2_idle", 3'd0, 2'd3, 1'b0);
    step(1);
    expect_st("btn_edge3_play", 3'd1, 2'd3, 1'b0);
    step(2);
    expect_st("play_holds", 3'd1, 2'd3, 1'b0);

    // one-cycle collision, frame tick five cycles later
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    expect_st("pending_no_tick", 3'd1, 2'd3, 1'b0);
    step(4);
    expect_st("pending_before_tick", 3'd1, 2'd3, 1'b0);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    expect_st("hit_entry", 3'd2, 2'd2, 1'b0);

    // HIT timing with collision held and a button rise that must be ignored
    collision = 1'b1;
    for (int i = 1; i <= 63; i++) begin
      if (i == 10) move_btn = 1'b0;
      if (i == 20) move_btn = 1'b1;
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      expect_st($sformatf("hit_tick%0d", i), 3'd2, 2'd2, logic'((i / 8) % 2));
      step(1);
    end
    collision = 1'b0;
    last_tick();
    expect_st("respawn_after_64", 3'd3, 2'd2, 1'b0);
    step(1);
    expect_st("play_after_respawn", 3'd1, 2'd2, 1'b0);
    step(2);
    expect_st("no_stale_pending", 3'd1, 2'd2, 1'b0);

    // second and third hits
    hit_now();
    expect_st("hit2_entry", 3'd2, 2'd1, 1'b0);
    repeat (63) tick();
    last_tick();
    expect_st("hit2_respawn", 3'd3, 2'd1, 1'b0);
    step(1);
    expect_st("hit2_play", 3'd1, 2'd1, 1'b0);
    hit_now();
    expect_st("hit3_entry", 3'd2, 2'd0, 1'b0);
    repeat (63) tick();
    last_tick();
    expect_st("over", 3'd4, 2'd0, 1'b0);
    collision = 1'b1;
    tick();
    collision = 1'b0;
    expect_st("over_holds", 3'd4, 2'd0, 1'b0);

    // restart from OVER
    move_btn = 1'b0;
    step(3);
    expect_st("over_no_rise", 3'd4, 2'd0, 1'b0);
    move_btn = 1'b1;
    step(2);
    expect_st("over_rise_pending", 3'd4, 2'd0, 1'b0);
    step(1);
    expect_st("restart_respawn", 3'd3, 2'd3, 1'b0);
    step(1);
    expect_st("restart_play", 3'd1, 2'd3, 1'b0);

    // reset in the middle of HIT (frame_cnt = 20)
    hit_now();
    expect_st("hit4_entry", 3'd2, 2'd2, 1'b0);
    repeat (20) tick();
    expect_st("hit4_cnt20", 3'd2, 2'd2, 1'b0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_st("reset_mid_hit", 3'd0, 2'd3, 1'b0);

    // reset in RESPAWN
    button_rise();
    expect_st("replay", 3'd1, 2'd3, 1'b0);
    hit_now();
    repeat (63) tick();
    last_tick();
    expect_st("respawn_before_reset", 3'd3, 2'd2, 1'b0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_st("reset_mid_respawn", 3'd0, 2'd3, 1'b0);
    step(2);
    expect_st("idle_after_reset", 3'd0, 2'd3, 1'b0);

    // bounded wait for PLAY after a fresh button press
    move_btn = 1'b0;
    step(3);
    move_btn = 1'b1;
    wait_state("wait_play_after_reset", 3'd1, 2'd3, 8);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0)
      $display("FAIL report: %0d expected vectors never compared", exp_q.size());
    if (pass_cnt != chk_cnt)
      $display("FAIL report: %0d of %0d checks failed", chk_cnt - pass_cnt, chk_cnt);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
